// File: rtl/mips_instr_encoder_if.sv
// Bus between the instruction-field producer and the MIPS encoder:
// an input field channel and an output word/address channel, each valid/ready.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;

  // Producer / program-writer side.
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs decoded MIPS fields into 32-bit words with sequential imem addresses, 2-entry output FIFO.
// Optional macro MIPS_ENC_BRANCH_REL_EN: BEQ immediate is an absolute word address turned into an offset.
module mips_instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  mips_instr_encoder_if.slave  bus,
  output logic                 full,
  output logic                 err
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the producer holds its payload until transferred.

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_LW    = 3'd1;
  localparam logic [2:0] OP_SW    = 3'd2;
  localparam logic [2:0] OP_BEQ   = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_J     = 3'd5;
  localparam logic [2:0] OP_JAL   = 3'd6;
  localparam logic [2:0] OP_JR    = 3'd7;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_next;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_instr;
  logic              skid_valid;
  logic [ADDR_W-1:0] skid_addr;
  logic [31:0]       skid_instr;
  logic              accept;
  logic              illegal;
  logic              push;
  logic              pop;
  logic [15:0]       beq_off;
  logic [31:0]       enc_word;

  assign bus.in_ready  = !start && !full && !skid_valid;
  assign bus.out_valid = head_valid;
  assign bus.out_addr  = head_addr;
  assign bus.out_instr = head_instr;

  assign accept    = bus.in_valid && bus.in_ready;
  assign illegal   = (bus.in_op == OP_RTYPE) && (bus.in_funct == FUNCT_JR);
  assign push      = accept && !illegal;
  assign pop       = head_valid && bus.out_ready;
  assign addr_next = addr_cnt + ADDR_W'(1);

`ifdef MIPS_ENC_BRANCH_REL_EN
  // Target is an absolute word address; offset counts from the word after the branch.
  assign beq_off = bus.in_imm - (16'(addr_cnt) + 16'd1);
`else
  assign beq_off = bus.in_imm;
`endif

  always_comb begin
    enc_word = '0;
    case (bus.in_op)
      OP_RTYPE: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
      OP_LW:    enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_SW:    enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_BEQ:   enc_word = {6'b000100, bus.in_rs, bus.in_rt, beq_off};
      OP_ADDI:  enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_J:     enc_word = {6'b000010, bus.in_target};
      OP_JAL:   enc_word = {6'b000011, bus.in_target};
      OP_JR:    enc_word = {6'b000000, bus.in_rs, 15'b0, FUNCT_JR};
      default:  enc_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt   <= BASE;
      full       <= 1'b0;
      err        <= 1'b0;
      head_valid <= 1'b0;
      head_addr  <= '0;
      head_instr <= '0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_instr <= '0;
    end else if (start) begin
      addr_cnt   <= BASE;
      full       <= 1'b0;
      err        <= 1'b0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (accept && illegal) err <= 1'b1;
      if (push) begin
        addr_cnt <= addr_next;
        // Counter coming back round to its start means the whole imem has been assigned.
        if (addr_next == BASE) full <= 1'b1;
      end
      // Skid occupied implies in_ready=0, so push and a full FIFO never coincide.
      if (skid_valid) begin
        if (pop) begin
          head_addr  <= skid_addr;
          head_instr <= skid_instr;
          skid_valid <= 1'b0;
        end
      end else if (push) begin
        if (!head_valid || pop) begin
          head_valid <= 1'b1;
          head_addr  <= addr_cnt;
          head_instr <= enc_word;
        end else begin
          skid_valid <= 1'b1;
          skid_addr  <= addr_cnt;
          skid_instr <= enc_word;
        end
      end else if (pop) begin
        head_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_mips_instr_encoder;
  localparam int AW   = 2;
  localparam int BASE = 0;
  localparam int CAP  = 1 << AW;

  logic clk;
  logic reset;
  logic start;
  logic full;
  logic err;

  mips_instr_encoder_if #(.ADDR_W(AW)) ifc ();

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (ifc),
    .full  (full),
    .err   (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [AW+31:0] exp_q[$];   // {addr, instr}, oldest first
  int m_cnt;
  int m_words;
  bit m_full;
  bit m_err;
  bit m_rst_vals;             // outputs still hold their reset values
  bit m_acc;                  // last edge transferred an input

  function automatic logic [31:0] model_word(int op, int rs, int rt, int rd, int funct,
                                             int imm, int target, int addr);
    int off;
    case (op)
      0: return (rs << 21) + (rt << 16) + (rd << 11) + funct;
      1: return (35 << 26) + (rs << 21) + (rt << 16) + imm;
      2: return (43 << 26) + (rs << 21) + (rt << 16) + imm;
      3: begin
`ifdef MIPS_ENC_BRANCH_REL_EN
        off = (imm - (addr + 1)) & 16'hFFFF;
`else
        off = imm;
`endif
        return (4 << 26) + (rs << 21) + (rt << 16) + off;
      end
      4: return (8 << 26) + (rs << 21) + (rt << 16) + imm;
      5: return (2 << 26) + target;
      6: return (3 << 26) + target;
      default: return (rs << 21) + 8;
    endcase
  endfunction

  function automatic bit model_ready();
    return !start && !m_full && (exp_q.size() < 2);
  endfunction

  always @(posedge clk or negedge reset) begin
    bit rdy;
    bit pop;
    logic [31:0] w;
    m_acc = 1'b0;
    if (!reset) begin
      exp_q.delete();
      m_cnt = BASE; m_words = 0; m_full = 0; m_err = 0; m_rst_vals = 1;
    end else begin
      rdy = model_ready();
      pop = (exp_q.size() > 0) && ifc.out_ready;
      if (start) begin
        exp_q.delete();
        m_cnt = BASE; m_words = 0; m_full = 0; m_err = 0;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (ifc.in_valid && rdy) begin
          m_acc = 1'b1;
          if (ifc.in_op == 3'd0 && ifc.in_funct == 6'd8) begin
            m_err = 1;
          end else begin
            w = model_word(int'(ifc.in_op), int'(ifc.in_rs), int'(ifc.in_rt), int'(ifc.in_rd),
                           int'(ifc.in_funct), int'(ifc.in_imm), int'(ifc.in_target), m_cnt);
            exp_q.push_back({AW'(m_cnt), w});
            m_cnt = (m_cnt + 1) % CAP;
            m_words++;
            if (m_words == CAP) m_full = 1;
            m_rst_vals = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("out_valid", 32'(ifc.out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_addr", 32'(ifc.out_addr), 32'(exp_q[0][AW+31:32]));
      chk("out_instr", ifc.out_instr, exp_q[0][31:0]);
    end else if (m_rst_vals) begin
      chk("out_addr_rst", 32'(ifc.out_addr), 32'd0);
      chk("out_instr_rst", ifc.out_instr, 32'd0);
    end
    chk("in_ready", 32'(ifc.in_ready), 32'(model_ready()));
    chk("full", 32'(full), 32'(m_full));
    chk("err", 32'(err), 32'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int op, input int rs, input int rt, input int rd,
                            input int funct, input int imm, input int target);
    ifc.in_op     = 3'(op);
    ifc.in_rs     = 5'(rs);
    ifc.in_rt     = 5'(rt);
    ifc.in_rd     = 5'(rd);
    ifc.in_funct  = 6'(funct);
    ifc.in_imm    = 16'(imm);
    ifc.in_target = 26'(target);
  endtask

  // Presents one word and holds it until transferred (returns 1ns after that edge).
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int funct, input int imm, input int target);
    set_fields(op, rs, rt, rd, funct, imm, target);
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (m_acc) begin
        ifc.in_valid = 1'b0;
        return;
      end
    end
    ifc.in_valid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_head(input string name, input int addr, input logic [31:0] instr);
    @(negedge clk);
    chk({name, "_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({name, "_addr"}, 32'(ifc.out_addr), 32'(addr));
    chk(name, ifc.out_instr, instr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // ADDI then LW, one cycle latency each
    send(4, 0, 8, 0, 0, 5, 0);
    expect_head("addi", 0, 32'h20080005);
    send(1, 3, 2, 0, 0, 4, 0);
    expect_head("lw", 1, 32'h8C620004);

    // R-type, JR, J, JAL fill a 4-word imem
    pulse_start();
    send(0, 1, 2, 3, 6'b100000, 0, 0);
    expect_head("rtype", 0, 32'h00221820);
    send(7, 31, 0, 0, 0, 0, 0);
    expect_head("jr", 1, 32'h03E00008);
    send(5, 0, 0, 0, 0, 0, 'h10);
    expect_head("j", 2, 32'h08000010);
    send(6, 0, 0, 0, 0, 0, 'h10);
    expect_head("jal", 3, 32'h0C000010);
    chk("full_set", 32'(full), 32'd1);
    set_fields(4, 1, 1, 0, 0, 1, 0);
    ifc.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    pulse_start();
    chk("full_cleared", 32'(full), 32'd0);
    send(4, 0, 8, 0, 0, 5, 0);
    expect_head("restart", 0, 32'h20080005);

    // backpressure: two words buffered, third waits
    pulse_start();
    ifc.out_ready = 1'b0;
    send(4, 0, 8, 0, 0, 5, 0);
    send(1, 3, 2, 0, 0, 4, 0);
    set_fields(5, 0, 0, 0, 0, 'h10, 'h10);
    ifc.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("bp_head", ifc.out_instr, 32'h20080005);
    @(negedge clk);
    chk("bp_head_hold", ifc.out_instr, 32'h20080005);
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    send(5, 0, 0, 0, 0, 'h10, 'h10);
    expect_head("bp_third", 2, 32'h08000010);

    // illegal R-type with JR funct
    pulse_start();
    send(1, 3, 2, 0, 0, 4, 0);
    expect_head("pre_illegal", 0, 32'h8C620004);
    send(0, 1, 2, 3, 6'b001000, 0, 0);
    @(negedge clk);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_no_out", 32'(ifc.out_valid), 32'd0);
    send(4, 0, 8, 0, 0, 5, 0);
    expect_head("post_illegal", 1, 32'h20080005);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    send(4, 0, 8, 0, 0, 5, 0);
    expect_head("after_start", 0, 32'h20080005);

    // BEQ after three fillers lands at addr 3
    pulse_start();
    send(4, 0, 8, 0, 0, 5, 0);
    send(4, 0, 8, 0, 0, 5, 0);
    send(4, 0, 8, 0, 0, 5, 0);
    send(3, 1, 2, 0, 0, 1, 0);
`ifdef MIPS_ENC_BRANCH_REL_EN
    expect_head("beq", 3, 32'h1022FFFD);
`else
    expect_head("beq", 3, 32'h10220001);
`endif

    // reset mid-stream
    pulse_start();
    ifc.out_ready = 1'b0;
    send(4, 0, 8, 0, 0, 5, 0);
    send(1, 3, 2, 0, 0, 4, 0);
    #3 reset = 1'b0;
    #1 chk("midreset_valid", 32'(ifc.out_valid), 32'd0);
    chk("midreset_instr", ifc.out_instr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ifc.out_ready = 1'b1;
    send(1, 3, 2, 0, 0, 4, 0);
    expect_head("post_reset", 0, 32'h8C620004);

    // randomized traffic with held-valid semantics
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (m_acc || !ifc.in_valid) begin
        set_fields($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31),
                   ($urandom_range(0, 5) == 0) ? 8 : $urandom_range(0, 63),
                   $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF));
        ifc.in_valid = ($urandom_range(0, 3) != 0);
      end
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      start = m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
    end
    @(posedge clk); #1;
    ifc.in_valid  = 1'b0;
    start         = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained", 32'(ifc.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
